// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit serializer.
// UART_TX_PARITY_EN adds an even-parity bit to every frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  function automatic logic even_par(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO; push and pop may share an edge, even when full.
// Occupancy is one bit wider than the pointers so full and empty differ.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 full,
  output logic                 empty,
  output logic                 accept
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  do_pop;

  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);
  assign do_pop = pop & ~empty;
  assign accept = push & (~full | do_pop);
  assign dout   = mem[rptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      unique case ({accept, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // storage needs no reset; only occupied slots are ever read
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte FIFO feeding an LSB-first async serial transmitter (8N1).
// Define UART_TX_PARITY_EN for an even-parity bit after the data.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_DIV         = 16,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int LOG             = 0
) (
  input  logic                       clk,
  input  logic                       mr,
  input  logic [7:0]                 d,
  input  logic                       _wr,
  output logic                       _txe,
  output logic                       busy,
  output logic                       overflow,
  output logic [FIFO_DEPTH_LOG2:0]   level,
  output logic                       txd
);

  localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
    $error("CLK_DIV must lie in 2..65535");
  end
  if (LOG != 0 && LOG != 1) begin : g_bad_log
    $error("LOG must be 0 or 1");
  end

  tx_state_t            state;
  tx_state_t            state_n;
  logic [15:0]          cnt;
  logic [15:0]          cnt_n;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_n;
  logic [2:0]           bit_idx;
  logic [2:0]           bit_idx_n;
  logic                 txd_n;
  logic                 wr_prev;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic [DATA_BITS-1:0] head;

  // a held-low strobe only counts once: trigger on its falling edge
  assign push = wr_prev & ~_wr;

  byte_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .rst    (mr),
    .push   (push),
    .pop    (pop),
    .din    (d),
    .dout   (head),
    .level  (level),
    .full   (full),
    .empty  (empty),
    .accept (accept)
  );

  assign _txe = full;
  assign busy = (state != IDLE) | ~empty;

  // strobe history and sticky drop flag
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      wr_prev  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_prev <= _wr;
      if (push & ~accept) overflow <= 1'b1;
    end
  end

  // transmitter state register; txd is driven straight from a flop
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      txd     <= txd_n;
    end
  end

  // next-state: each state holds one bit time, then advances
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    txd_n     = txd;
    pop       = 1'b0;
    if (state != IDLE && cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = head;
            txd_n   = 1'b0;
            cnt_n   = BAUD_LOAD;
            state_n = START;
          end
        end
        START: begin
          state_n   = DATA;
          bit_idx_n = '0;
          txd_n     = shreg[0];
          cnt_n     = BAUD_LOAD;
        end
        DATA: begin
          cnt_n = BAUD_LOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            txd_n   = even_par(shreg);
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            txd_n     = shreg[bit_idx_n];
          end
        end
        PARITY: begin
          state_n = STOP;
          txd_n   = 1'b1;
          cnt_n   = BAUD_LOAD;
        end
        STOP: begin
          // chain straight into the next frame when data waits
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = head;
            txd_n   = 1'b0;
            cnt_n   = BAUD_LOAD;
            state_n = START;
          end else begin
            txd_n   = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          txd_n   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: written bytes are queued, decoded txd frames compared.
// Build with UART_TX_PARITY_EN defined to also exercise the parity frame.
`timescale 1ns/1ps
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int DIV = 4;
  localparam int DL2 = 2;
  localparam int FB  = FRAME_BITS;
  localparam int N   = FB * DIV;

  logic           clk = 1'b0;
  logic           mr  = 1'b1;
  logic [7:0]     d   = '0;
  logic           _wr = 1'b1;
  logic           _txe;
  logic           busy;
  logic           overflow;
  logic [DL2:0]   level;
  logic           txd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         ok;
    bit         par;
    int         start;
  } rx_t;

  rx_t        rx_q[$];
  logic [7:0] exp_q[$];

  uart_tx_serializer #(
    .CLK_DIV(DIV), .FIFO_DEPTH_LOG2(DL2), .LOG(0)
  ) dut (
    .clk(clk), .mr(mr), .d(d), ._wr(_wr), ._txe(_txe),
    .busy(busy), .overflow(overflow), .level(level), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // line monitor: decodes frames sampled at every falling clock edge
  initial begin : monitor
    logic [N-1:0] s;
    rx_t r;
    bit abort;
    forever begin
      @(negedge clk);
      if (mon_en && !mr && txd === 1'b0) begin
        r.start = cyc;
        abort = 1'b0;
        s[0] = txd;
        for (int j = 1; j < N; j++) begin
          @(negedge clk);
          if (mr) abort = 1'b1;
          s[j] = txd;
        end
        r.ok = 1'b1;
        r.data = '0;
        r.par = 1'b0;
        for (int b = 0; b < FB; b++)
          for (int j = 1; j < DIV; j++)
            if (s[b*DIV+j] !== s[b*DIV]) r.ok = 1'b0;
        if (s[0] !== 1'b0 || s[N-1] !== 1'b1) r.ok = 1'b0;
        for (int b = 0; b < 8; b++) r.data[b] = s[(b+1)*DIV];
        if (FB == 11) r.par = s[9*DIV];
        if (!abort) rx_q.push_back(r);
      end
    end
  end

  task automatic write_byte(input logic [7:0] b, output int k);
    @(negedge clk);
    d = b;
    _wr = 1'b0;
    @(negedge clk);
    k = cyc;
    _wr = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mr = 1'b1;
    @(negedge clk);
    mr = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output int fall, output bit ok);
    ok = 1'b0;
    fall = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin
        fall = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      errors++; $display("FAIL reset_txd got %b want 1", txd);
    end
    checks++;
    if (_txe !== 1'b0) begin
      errors++; $display("FAIL reset_txe got %b want 0", _txe);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", overflow);
    end
    checks++;
    if (level !== 3'd0) begin
      errors++; $display("FAIL reset_level got %0d want 0", level);
    end
    mr = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int k, fall;
    bit ok;
    rx_t r;
    logic [7:0] e;
    exp_q.push_back(8'hA5);
    write_byte(8'hA5, k);
    checks++;
    if (level !== 3'd1) begin
      errors++; $display("FAIL single_level got %0d want 1", level);
    end
    wait_idle(fall, ok);
    checks++;
    if (!ok || fall != k + 1 + N) begin
      errors++; $display("FAIL single_busy_end got %0d want %0d", fall, k + 1 + N);
    end
    wait_rx(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_timeout got 0 frames want 1");
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.data !== e) begin
        errors++; $display("FAIL single_data got %h want %h", r.data, e);
      end
      checks++;
      if (!r.ok) begin
        errors++; $display("FAIL single_framing got bad want good");
      end
      checks++;
      if (r.start != k + 1) begin
        errors++; $display("FAIL single_latency got %0d want %0d", r.start, k + 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int k, lows;
    mon_en = 1'b0;
    write_byte(8'hA5, k);
    for (int i = 0; i < 100 && cyc < k + 1 + 3 * DIV; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midrst_busy_before got %b want 1", busy);
    end
    mr = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) begin
      errors++; $display("FAIL midrst_txd got %b want 1", txd);
    end
    checks++;
    if (level !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_state got lvl %0d busy %b want 0 0", level, busy);
    end
    @(negedge clk);
    mr = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", lows);
    end
    rx_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int k1, k2, fall;
    bit ok;
    rx_t r1, r2;
    logic [7:0] e;
    exp_q.push_back(8'h00);
    write_byte(8'h00, k1);
    exp_q.push_back(8'hFF);
    write_byte(8'hFF, k2);
    wait_idle(fall, ok);
    checks++;
    if (!ok || fall != k1 + 1 + 2 * N) begin
      errors++; $display("FAIL b2b_busy_end got %0d want %0d", fall, k1 + 1 + 2 * N);
    end
    wait_rx(2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_timeout got %0d frames want 2", rx_q.size());
    end else begin
      r1 = rx_q.pop_front();
      r2 = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r1.data !== e || !r1.ok) begin
        errors++; $display("FAIL b2b_first got %h ok %b want %h", r1.data, r1.ok, e);
      end
      e = exp_q.pop_front();
      checks++;
      if (r2.data !== e || !r2.ok) begin
        errors++; $display("FAIL b2b_second got %h ok %b want %h", r2.data, r2.ok, e);
      end
      checks++;
      if (r2.start != r1.start + N) begin
        errors++; $display("FAIL b2b_gap got %0d want %0d", r2.start, r1.start + N);
      end
    end
  endtask

  task automatic test_fill();
    int k, fall;
    bit ok;
    rx_t r;
    logic [7:0] e;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i * 17));
      write_byte(8'(i * 17), k);
    end
    checks++;
    if (level !== 3'd4 || _txe !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got lvl %0d txe %b ovf %b want 4 1 0", level, _txe, overflow);
    end
    write_byte(8'hEE, k);
    checks++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      errors++; $display("FAIL fill_drop got ovf %b lvl %0d want 1 4", overflow, level);
    end
    wait_idle(fall, ok);
    wait_rx(5, ok);
    checks++;
    if (!ok || rx_q.size() != 5) begin
      errors++; $display("FAIL fill_count got %0d frames want 5", rx_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.data !== e || !r.ok) begin
        errors++; $display("FAIL fill_data got %h ok %b want %h", r.data, r.ok, e);
      end
    end
    checks++;
    if (overflow !== 1'b1 || _txe !== 1'b0) begin
      errors++; $display("FAIL fill_sticky got ovf %b txe %b want 1 0", overflow, _txe);
    end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL fill_clear got %b want 0", overflow);
    end
  endtask

  task automatic test_held_low();
    int k, s, fall;
    bit ok;
    rx_t r;
    logic [7:0] e;
    do_reset();
    @(negedge clk);
    d = 8'h3C;
    _wr = 1'b0;
    exp_q.push_back(8'h3C);
    repeat (10) @(negedge clk);
    _wr = 1'b1;
    wait_idle(fall, ok);
    wait_rx(1, ok);
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL held_count got %0d frames want 1", rx_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.data !== e || !r.ok) begin
        errors++; $display("FAIL held_data got %h want %h", r.data, e);
      end
    end
    rx_q.delete();
    exp_q.delete();
    exp_q.push_back(8'h81);
    write_byte(8'h81, k);
    s = k + 1;
    for (int i = 2; i <= 5; i++) begin
      exp_q.push_back(8'(i * 3));
      write_byte(8'(i * 3), k);
    end
    for (int i = 0; i < 200 && cyc < s + N - 1; i++) @(negedge clk);
    checks++;
    if (level !== 3'd4 || _txe !== 1'b1) begin
      errors++; $display("FAIL popwr_pre got lvl %0d txe %b want 4 1", level, _txe);
    end
    d = 8'hE7;
    _wr = 1'b0;
    exp_q.push_back(8'hE7);
    @(negedge clk);
    _wr = 1'b1;
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL popwr_accept got lvl %0d ovf %b want 4 0", level, overflow);
    end
    wait_idle(fall, ok);
    wait_rx(6, ok);
    checks++;
    if (!ok || rx_q.size() != 6) begin
      errors++; $display("FAIL popwr_count got %0d frames want 6", rx_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.data !== e || !r.ok) begin
        errors++; $display("FAIL popwr_data got %h ok %b want %h", r.data, r.ok, e);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int k, fall;
    bit ok;
    rx_t r;
    logic [7:0] pb [2];
    bit pexp [2];
    pb[0] = 8'h07;
    pb[1] = 8'h03;
    pexp[0] = 1'b1;
    pexp[1] = 1'b0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      write_byte(pb[i], k);
      wait_idle(fall, ok);
      checks++;
      if (!ok || fall != k + 1 + 44) begin
        errors++; $display("FAIL par_len got %0d want %0d", fall, k + 45);
      end
      wait_rx(1, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL par_timeout got 0 frames want 1");
      end else begin
        r = rx_q.pop_front();
        checks++;
        if (r.data !== pb[i] || r.par !== pexp[i] || !r.ok) begin
          errors++;
          $display("FAIL par_bit got %h p%b want %h p%b", r.data, r.par, pb[i], pexp[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_reset_mid_frame();
    test_back_to_back();
    test_fill();
    test_held_low();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
